// File: rtl/rv32i_exec_mem_unit_pkg.sv
// Shared constants for the RV32I execute/memory slice: opcodes, ALU codes,
// immediate-format codes and the decoded control bundle.
package rv32i_exec_mem_unit_pkg;

  localparam int DATA_WIDTH_DEF     = 32;
  localparam int MEM_ADDR_WIDTH_DEF = 10;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_op_e;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_U = 2'b11
  } imm_src_e;

  typedef struct packed {
    logic     branch;
    logic     mem_read;
    logic     mem_2_reg;
    logic     mem_write;
    logic     alu_src;
    logic     reg_write;
    imm_src_e imm_src;
    alu_op_e  alu_ctrl;
  } ctrl_t;

  // funct7[5] selects SUB only on register-register ops; on OP-IMM it is an
  // immediate bit for ADDI and only means "arithmetic" for the right shift.
  function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic alt,
                                         input logic is_r);
    case (f3)
      3'b000:  return (alt && is_r) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/rv32i_exec_mem_unit_data_ram.sv
// Word data memory: synchronous write, combinational read, optional debug read
// port enabled by DEBUG_PORT_EN (otherwise debug data reads as 0).
module rv32i_exec_mem_unit_data_ram
  import rv32i_exec_mem_unit_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int MEM_ADDR_WIDTH = MEM_ADDR_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_we,
  input  logic [MEM_ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0]     i_wdata,
  input  logic [MEM_ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0]     o_rdata,
  input  logic [MEM_ADDR_WIDTH-1:0] i_dbg_addr,
  output logic [DATA_WIDTH-1:0]     o_dbg_data
);

  logic [DATA_WIDTH-1:0] r_mem [2**MEM_ADDR_WIDTH];

  // Reset only blocks writes; the array itself is never cleared.
  always_ff @(posedge clk) begin
    if (rst && i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

`ifdef DEBUG_PORT_EN
  assign o_dbg_data = r_mem[i_dbg_addr];
`else
  logic w_unused_dbg;
  assign w_unused_dbg = ^i_dbg_addr;
  assign o_dbg_data   = '0;
`endif

endmodule

// File: rtl/rv32i_exec_mem_unit.sv
// Single-cycle RV32I decode/ALU/data-memory slice. Define DEBUG_PORT_EN to
// expose a combinational debug read of the data memory on debug_data.
module rv32i_exec_mem_unit
  import rv32i_exec_mem_unit_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int MEM_ADDR_WIDTH = MEM_ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           instr,
  input  logic [DATA_WIDTH-1:0] rs1_val,
  input  logic [DATA_WIDTH-1:0] rs2_val,
  input  logic [DATA_WIDTH-1:0] imm,
  input  logic                  init_done,
  input  logic [DATA_WIDTH-1:0] ext_w_addr,
  input  logic [DATA_WIDTH-1:0] ext_w_dat,
  input  logic                  ext_w_enb,
  output logic                  branch,
  output logic                  mem_read,
  output logic                  mem_2_reg,
  output logic                  mem_write,
  output logic                  alu_src,
  output logic                  reg_write,
  output logic [1:0]            imm_src,
  output logic [3:0]            alu_ctrl,
  output logic [DATA_WIDTH-1:0] alu_result,
  output logic                  zero,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] wb_data,
  input  logic [DATA_WIDTH-1:0] debug_addr,
  output logic [DATA_WIDTH-1:0] debug_data
);

  localparam int SHW = $clog2(DATA_WIDTH);
  localparam int AW  = MEM_ADDR_WIDTH;

  logic [6:0]            w_opcode;
  logic [2:0]            w_f3;
  logic                  w_f7b5;
  ctrl_t                 w_ctrl;
  logic [DATA_WIDTH-1:0] w_op_b;
  logic [DATA_WIDTH-1:0] w_alu;
  logic                  w_we;
  logic [AW-1:0]         w_waddr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_ram_rdata;
  logic                  w_unused_bits;

  assign w_opcode = instr[6:0];
  assign w_f3     = instr[14:12];
  assign w_f7b5   = instr[30];

  // Decoder; holding rst low forces the idle bundle (all flags 0, ADD).
  always_comb begin
    w_ctrl          = '0;
    w_ctrl.imm_src  = IMM_I;
    w_ctrl.alu_ctrl = ALU_ADD;
    if (rst) begin
      case (w_opcode)
        OP_R: begin
          w_ctrl.reg_write = 1'b1;
          w_ctrl.alu_ctrl  = alu_decode(w_f3, w_f7b5, 1'b1);
        end
        OP_I: begin
          w_ctrl.reg_write = 1'b1;
          w_ctrl.alu_src   = 1'b1;
          w_ctrl.alu_ctrl  = alu_decode(w_f3, w_f7b5, 1'b0);
        end
        OP_LW: begin
          w_ctrl.mem_read  = 1'b1;
          w_ctrl.mem_2_reg = 1'b1;
          w_ctrl.reg_write = 1'b1;
          w_ctrl.alu_src   = 1'b1;
        end
        OP_SW: begin
          w_ctrl.mem_write = 1'b1;
          w_ctrl.alu_src   = 1'b1;
          w_ctrl.imm_src   = IMM_S;
        end
        OP_BEQ: begin
          w_ctrl.branch   = 1'b1;
          w_ctrl.imm_src  = IMM_B;
          w_ctrl.alu_ctrl = ALU_SUB;
        end
        default: ;
      endcase
    end
  end

  assign w_op_b = w_ctrl.alu_src ? imm : rs2_val;

  always_comb begin
    w_alu = '0;
    case (w_ctrl.alu_ctrl)
      ALU_ADD:  w_alu = rs1_val + w_op_b;
      ALU_SUB:  w_alu = rs1_val - w_op_b;
      ALU_AND:  w_alu = rs1_val & w_op_b;
      ALU_OR:   w_alu = rs1_val | w_op_b;
      ALU_XOR:  w_alu = rs1_val ^ w_op_b;
      ALU_SLL:  w_alu = rs1_val << w_op_b[SHW-1:0];
      ALU_SRL:  w_alu = rs1_val >> w_op_b[SHW-1:0];
      ALU_SRA:  w_alu = $signed(rs1_val) >>> w_op_b[SHW-1:0];
      ALU_SLT:  w_alu = {{(DATA_WIDTH-1){1'b0}}, $signed(rs1_val) < $signed(w_op_b)};
      ALU_SLTU: w_alu = {{(DATA_WIDTH-1){1'b0}}, rs1_val < w_op_b};
      default:  w_alu = '0;
    endcase
  end

  // Until init_done the write port belongs to the external preloader.
  assign w_we    = init_done ? w_ctrl.mem_write : ext_w_enb;
  assign w_waddr = init_done ? w_alu[AW+1:2]    : ext_w_addr[AW+1:2];
  assign w_wdata = init_done ? rs2_val          : ext_w_dat;

  rv32i_exec_mem_unit_data_ram #(
    .DATA_WIDTH    (DATA_WIDTH),
    .MEM_ADDR_WIDTH(MEM_ADDR_WIDTH)
  ) u_ram (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_we),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata),
    .i_raddr   (w_alu[AW+1:2]),
    .o_rdata   (w_ram_rdata),
    .i_dbg_addr(debug_addr[AW+1:2]),
    .o_dbg_data(debug_data)
  );

  assign w_unused_bits = ^{instr[31], instr[29:15], instr[11:7],
                           ext_w_addr[DATA_WIDTH-1:AW+2], ext_w_addr[1:0],
                           debug_addr[DATA_WIDTH-1:AW+2], debug_addr[1:0]};

  assign branch     = w_ctrl.branch;
  assign mem_read   = w_ctrl.mem_read;
  assign mem_2_reg  = w_ctrl.mem_2_reg;
  assign mem_write  = w_ctrl.mem_write;
  assign alu_src    = w_ctrl.alu_src;
  assign reg_write  = w_ctrl.reg_write;
  assign imm_src    = w_ctrl.imm_src;
  assign alu_ctrl   = w_ctrl.alu_ctrl;
  assign alu_result = w_alu;
  assign zero       = (w_alu == '0);
  assign mem_rdata  = w_ctrl.mem_read ? w_ram_rdata : '0;
  assign wb_data    = w_ctrl.mem_2_reg ? mem_rdata : w_alu;

endmodule

// File: tb/tb_rv32i_exec_mem_unit.sv
// Directed self-checking bench for rv32i_exec_mem_unit.
module tb_rv32i_exec_mem_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr, rs1_val, rs2_val, imm;
  logic        init_done;
  logic [31:0] ext_w_addr, ext_w_dat;
  logic        ext_w_enb;
  logic        branch, mem_read, mem_2_reg, mem_write, alu_src, reg_write;
  logic [1:0]  imm_src;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        zero;
  logic [31:0] mem_rdata, wb_data;
  logic [31:0] debug_addr, debug_data;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [31:0] I_ADD  = 32'h005505B3;
  localparam logic [31:0] I_LW4  = 32'h00402283;
  localparam logic [31:0] I_LW8  = 32'h00802283;
  localparam logic [31:0] I_SW8  = 32'h00602423;
  localparam logic [31:0] I_BEQ  = 32'h00208063;
  localparam logic [31:0] I_BAD  = 32'h0000007F;

  rv32i_exec_mem_unit dut (
    .clk(clk), .rst(rst), .instr(instr), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .imm(imm), .init_done(init_done), .ext_w_addr(ext_w_addr),
    .ext_w_dat(ext_w_dat), .ext_w_enb(ext_w_enb), .branch(branch),
    .mem_read(mem_read), .mem_2_reg(mem_2_reg), .mem_write(mem_write),
    .alu_src(alu_src), .reg_write(reg_write), .imm_src(imm_src),
    .alu_ctrl(alu_ctrl), .alu_result(alu_result), .zero(zero),
    .mem_rdata(mem_rdata), .wb_data(wb_data), .debug_addr(debug_addr),
    .debug_data(debug_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] flags();
    return {26'd0, branch, mem_read, mem_2_reg, mem_write, alu_src, reg_write};
  endfunction

  // Apply one instruction at the falling edge and settle before sampling.
  task automatic drive(input logic [31:0] ins, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] im);
    @(negedge clk);
    instr = ins; rs1_val = a; rs2_val = b; imm = im;
    #1;
  endtask

  initial begin
    rst = 1'b0; instr = '0; rs1_val = '0; rs2_val = '0; imm = '0;
    init_done = 1'b0; ext_w_addr = '0; ext_w_dat = '0; ext_w_enb = 1'b0;
    debug_addr = '0;

    drive(I_ADD, 32'h8, 32'h8, 32'h0);
    chk("rst_flags", flags(), 32'h0);
    chk("rst_aluctrl", {28'd0, alu_ctrl}, 32'h0);
    chk("rst_rdata", mem_rdata, 32'h0);

    @(negedge clk); rst = 1'b1; instr = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      ext_w_enb  = 1'b1;
      ext_w_addr = i * 4;
      ext_w_dat  = (i == 1) ? 32'hDEADBEEF : 32'hA0000000 + i;
    end
    @(negedge clk);
    ext_w_enb = 1'b0; init_done = 1'b1; debug_addr = 32'h24;
    #1;
`ifdef DEBUG_PORT_EN
    chk("debug_w9", debug_data, 32'hA0000009);
`else
    chk("debug_off", debug_data, 32'h0);
`endif

    drive(I_ADD, 32'h8, 32'h8, 32'h0);
    chk("add_flags", flags(), 32'h01);
    chk("add_res", alu_result, 32'h10);
    chk("add_wb", wb_data, 32'h10);

    drive(I_LW4, 32'h0, 32'h0, 32'h4);
    chk("lw_flags", flags(), 32'h1B);
    chk("lw_rdata", mem_rdata, 32'hDEADBEEF);
    chk("lw_wb", wb_data, 32'hDEADBEEF);

    drive(I_LW8, 32'h0, 32'h0, 32'h8);
    chk("lw8_pre", mem_rdata, 32'hA0000002);

    drive(I_SW8, 32'h0, 32'h1234, 32'h8);
    chk("sw_flags", flags(), 32'h06);
    chk("sw_immsrc", {30'd0, imm_src}, 32'h1);
    chk("sw_addr", alu_result, 32'h8);
    chk("sw_rdata0", mem_rdata, 32'h0);

    drive(I_LW8, 32'h0, 32'h0, 32'h8);
    chk("lw8_post_sw", mem_rdata, 32'h1234);

    // External write and load to the same word in one cycle.
    @(negedge clk);
    init_done = 1'b0; ext_w_enb = 1'b1; ext_w_addr = 32'h8; ext_w_dat = 32'h5678;
    #1;
    chk("wr_rd_old", mem_rdata, 32'h1234);
    @(negedge clk);
    ext_w_enb = 1'b0; init_done = 1'b1;
    #1;
    chk("wr_rd_new", mem_rdata, 32'h5678);

    drive(I_LW8, 32'h1000, 32'h0, 32'hB);
    chk("addr_wrap", mem_rdata, 32'h5678);

    drive(I_BEQ, 32'h55, 32'h55, 32'h0);
    chk("beq_flags", flags(), 32'h20);
    chk("beq_ctrl", {28'd0, alu_ctrl}, 32'h1);
    chk("beq_zero", {31'd0, zero}, 32'h1);
    chk("beq_immsrc", {30'd0, imm_src}, 32'h2);
    drive(I_BEQ, 32'h55, 32'h54, 32'h0);
    chk("beq_ne_zero", {31'd0, zero}, 32'h0);

    drive(I_BAD, 32'h1, 32'h2, 32'h3);
    chk("bad_flags", flags(), 32'h0);
    chk("bad_ctrl", {28'd0, alu_ctrl}, 32'h0);

    drive(32'h40000033, 32'h5, 32'h7, 32'h0);
    chk("sub_res", alu_result, 32'hFFFFFFFE);
    chk("sub_ctrl", {28'd0, alu_ctrl}, 32'h1);
    drive(32'h40005013, 32'h80000000, 32'h0, 32'h404);
    chk("srai_res", alu_result, 32'hF8000000);
    chk("srai_ctrl", {28'd0, alu_ctrl}, 32'h7);
    drive(32'h00005033, 32'h80000000, 32'h4, 32'h0);
    chk("srl_res", alu_result, 32'h08000000);
    drive(32'h00002033, 32'hFFFFFFFF, 32'h1, 32'h0);
    chk("slt_res", alu_result, 32'h1);
    chk("slt_ctrl", {28'd0, alu_ctrl}, 32'h8);
    drive(32'h00003033, 32'hFFFFFFFF, 32'h1, 32'h0);
    chk("sltu_res", alu_result, 32'h0);
    chk("sltu_ctrl", {28'd0, alu_ctrl}, 32'h9);
    drive(32'h00004013, 32'h0000F0F0, 32'h0, 32'hFFFFFFFF);
    chk("xori_res", alu_result, 32'hFFFF0F0F);
    drive(32'h40000013, 32'h1, 32'h0, 32'h400);
    chk("addi_hi_res", alu_result, 32'h401);
    chk("addi_hi_ctrl", {28'd0, alu_ctrl}, 32'h0);
    drive(32'h00001033, 32'h1, 32'h21, 32'h0);
    chk("sll_res", alu_result, 32'h2);
    drive(32'h00007033, 32'hFF00FF00, 32'h0FF00FF0, 32'h0);
    chk("and_res", alu_result, 32'h0F000F00);
    drive(32'h00006033, 32'hFF00FF00, 32'h0FF00FF0, 32'h0);
    chk("or_res", alu_result, 32'hFFF0FFF0);

    @(negedge clk);
    rst = 1'b0; instr = I_SW8; rs1_val = 32'h0; rs2_val = 32'h9999; imm = 32'h8;
    #1;
    chk("rst_sw_flags", flags(), 32'h0);
    chk("rst_sw_rdata", mem_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b1; instr = I_LW8;
    #1;
    chk("rst_nowrite", mem_rdata, 32'h5678);
    chk("rst_resume", flags(), 32'h1B);

    debug_addr = 32'h8;
    #1;
`ifdef DEBUG_PORT_EN
    chk("debug_w2", debug_data, 32'h5678);
`else
    chk("debug_off2", debug_data, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
